// File: rtl/compare_arbiter.sv
// compare_arbiter
// Grants one of NUM_REQ requesters (round robin) access to a single shared
// combinational magnitude comparator. The operands are captured at grant,
// held for one settle cycle, and the registered result is returned over a
// valid/ready handshake.
module compare_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16,
  parameter int IDW     = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       grant,
  output logic [WIDTH-1:0]         cmp_a,
  output logic [WIDTH-1:0]         cmp_b,
  input  logic                     cmp_gt,
  input  logic                     cmp_lt,
  input  logic                     cmp_eq,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic                     rsp_gt,
  output logic                     rsp_lt,
  output logic                     rsp_eq,
  output logic                     busy,
  output logic                     err,
  output logic [15:0]              done_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // A healthy comparator asserts exactly one of gt/lt/eq.
  function automatic logic is_onehot3(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

  // Requester index + 1, wrapping at NUM_REQ (which need not be a power of two).
  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] v);
    logic [IDW-1:0] r;
    if (v == IDW'(NUM_REQ - 1)) begin
      r = '0;
    end else begin
      r = v + IDW'(1);
    end
    return r;
  endfunction

  state_t               state_q;
  logic [IDW-1:0]       rr_ptr_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic [WIDTH-1:0]     cmp_a_q;
  logic [WIDTH-1:0]     cmp_b_q;
  logic                 rsp_valid_q;
  logic [IDW-1:0]       rsp_id_q;
  logic                 rsp_gt_q;
  logic                 rsp_lt_q;
  logic                 rsp_eq_q;
  logic                 busy_q;
  logic                 err_q;
  logic [15:0]          done_count_q;

  logic                 pick_vld_d;
  logic [IDW-1:0]       pick_idx_d;
  logic [IDW:0]         cand_sum_d;
  logic [IDW-1:0]       cand_d;
  logic [NUM_REQ-1:0]   grant_d;
  logic [WIDTH-1:0]     sel_a_d;
  logic [WIDTH-1:0]     sel_b_d;

  // Round-robin search: first set req bit starting at rr_ptr, wrapping.
  always_comb begin
    pick_vld_d = 1'b0;
    pick_idx_d = '0;
    cand_sum_d = '0;
    cand_d     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_sum_d = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (cand_sum_d >= (IDW+1)'(NUM_REQ)) begin
        cand_sum_d = cand_sum_d - (IDW+1)'(NUM_REQ);
      end else begin
        cand_sum_d = cand_sum_d;
      end
      cand_d = cand_sum_d[IDW-1:0];
      if (!pick_vld_d && req[cand_d]) begin
        pick_vld_d = 1'b1;
        pick_idx_d = cand_d;
      end else begin
        pick_vld_d = pick_vld_d;
      end
    end
  end

  // Operand mux and one-hot grant for the selected requester.
  always_comb begin
    sel_a_d = req_a[int'(pick_idx_d)*WIDTH +: WIDTH];
    sel_b_d = req_b[int'(pick_idx_d)*WIDTH +: WIDTH];
    grant_d = NUM_REQ'(1) << pick_idx_d;
  end

  // Controller FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      cmp_a_q      <= '0;
      cmp_b_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_gt_q     <= 1'b0;
      rsp_lt_q     <= 1'b0;
      rsp_eq_q     <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      done_count_q <= 16'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_vld_d) begin
            cmp_a_q  <= sel_a_d;
            cmp_b_q  <= sel_b_d;
            grant_q  <= grant_d;
            rsp_id_q <= pick_idx_d;
            busy_q   <= 1'b1;
            state_q  <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          // Comparator has had one full cycle to settle on cmp_a/cmp_b.
          rsp_gt_q    <= cmp_gt;
          rsp_lt_q    <= cmp_lt;
          rsp_eq_q    <= cmp_eq;
          rsp_valid_q <= 1'b1;
          if (!is_onehot3({cmp_gt, cmp_lt, cmp_eq})) begin
            err_q <= 1'b1;
          end
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q  <= 1'b0;
            grant_q      <= '0;
            done_count_q <= done_count_q + 16'd1;
            // Served requester drops to lowest priority.
            rr_ptr_q     <= wrap_inc(rsp_id_q);
            busy_q       <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          grant_q     <= '0;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign grant      = grant_q;
  assign cmp_a      = cmp_a_q;
  assign cmp_b      = cmp_b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_gt     = rsp_gt_q;
  assign rsp_lt     = rsp_lt_q;
  assign rsp_eq     = rsp_eq_q;
  assign busy       = busy_q;
  assign err        = err_q;
  assign done_count = done_count_q;

endmodule

// File: doc/compare_arbiter.md
Name: compare_arbiter

Overview:
- Shares one 16-bit magnitude comparator (gt/lt/eq outputs) among NUM_REQ requesters.
- Round-robin arbitration selects a requester. The block latches its operands, drives the shared comparator, registers the result and returns it over a valid/ready response handshake.
- Sits between the requesting blocks and the single comparator instance. The comparator stays purely combinational and is connected through the cmp_* ports.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 16, operand width; must match the comparator
- IDW, 2, width of requester index; must equal ceil(log2(NUM_REQ))

Ports:
- clk, input, 1, single clock; all state updates on rising edge
- rst, input, 1, synchronous active-high reset
- req, input, NUM_REQ, per-requester request level
- req_a, input, NUM_REQ*WIDTH, flattened operand A; requester i occupies bits [i*WIDTH +: WIDTH]
- req_b, input, NUM_REQ*WIDTH, flattened operand B, same packing
- grant, output, NUM_REQ, one-hot grant of the requester being served
- cmp_a, output, WIDTH, registered operand A to the shared comparator
- cmp_b, output, WIDTH, registered operand B to the shared comparator
- cmp_gt, input, 1, comparator gt
- cmp_lt, input, 1, comparator lt
- cmp_eq, input, 1, comparator eq
- rsp_valid, output, 1, response available
- rsp_ready, input, 1, consumer accepts response
- rsp_id, output, IDW, index of the served requester
- rsp_gt, output, 1, registered gt result
- rsp_lt, output, 1, registered lt result
- rsp_eq, output, 1, registered eq result
- busy, output, 1, high in any state other than IDLE
- err, output, 1, sticky flag: comparator result was not one-hot
- done_count, output, 16, completed transactions; wraps 0xFFFF -> 0

Behaviour:
- Reset (sync, rst=1 at edge):
  - state=IDLE, rr_ptr=0.
  - grant, cmp_a, cmp_b, rsp_*, err and done_count all = 0.
  - An in-flight transaction is discarded with no response.
- FSM states: IDLE, DRIVE, RESP.
- IDLE:
  - If any req bit is set, select the first set bit scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - On that edge: latch the selected req_a/req_b into cmp_a/cmp_b, set grant one-hot, set rsp_id, go to DRIVE.
  - No req set: remain in IDLE; all outputs hold.
- DRIVE (exactly 1 cycle; the comparator settles):
  - At the edge, register cmp_gt/lt/eq into rsp_gt/lt/eq, set rsp_valid=1, go to RESP.
  - If {cmp_gt,cmp_lt,cmp_eq} is not exactly one-hot, set err=1. err clears only on rst.
- RESP:
  - rsp_valid stays high; rsp_id and rsp_* are stable until rsp_ready=1 at an edge.
  - On acceptance: rsp_valid=0, grant=0, done_count+=1, rr_ptr=(rsp_id+1) mod NUM_REQ, go to IDLE.
  - rsp_* keep their last values after acceptance.
- Latency and throughput:
  - req sampled at edge 0 -> rsp_valid high after edge 1.
  - With rsp_ready held high, acceptance occurs at edge 2 and the next grant at edge 3.
  - Maximum throughput is one compare per 3 cycles; there is no back-to-back issue from RESP.
- Operands are captured at grant. Requesters may change req_a/req_b or drop req after grant without affecting the result.
- A req dropped before grant is simply not served. A requester holding req high after its response is eligible again, but at lowest priority.
- Fairness: with all requesters continuously requesting, the grant order is 0,1,2,3,0,... and no requester waits more than NUM_REQ-1 transactions.
- cmp_a/cmp_b hold their last values outside DRIVE; they are don't-care for the comparator.
- rst asserted in any state, including simultaneously with rsp_ready, takes precedence: no count increment, return to IDLE.

Test Plan:
- Single request: req=0001, a0=0x1234, b0=0x1200; hold rsp_ready=1 -> grant=0001, rsp_valid after 2 edges, rsp_id=0, gt=1 lt=0 eq=0, done_count=1.
- Equality and less-than: requester 2 sends a=0xFFFF,b=0xFFFF -> eq=1. Then a=0x0000,b=0x8000 -> lt=1. Unsigned compare: 0x8000 > 0x7FFF gives gt=1.
- Round robin: req=1111 held, rsp_ready=1, 8 transactions -> rsp_id sequence 0,1,2,3,0,1,2,3. Then req=1010 after serving id1 -> next ids 3,1,3.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_id and rsp_* stable, busy=1, no new grant. Operands changed after grant do not alter the result. rsp_ready=1 -> accept, IDLE next cycle.
- Error flag: stub comparator returns gt=1,eq=1 -> err=1 after DRIVE and stays 1 through later clean transactions until rst.
- Reset mid-operation: assert rst during DRIVE and again during RESP with rsp_ready=1 -> all outputs 0, done_count unchanged from 0, next grant starts from requester 0.
